alu_issue_ctrl: RTL and testbench

Sequencer on the requester side of the ALU core interface. It accepts one decoded ALU request per handshake and drives the ALU opcode, operands and flag inputs. It waits a fixed settle time, captures the ALU results and updates the PSW flags it owns (CY, AC, OV). It then presents the result to the execute stage with a valid/ready handshake. The ALU evaluates only when its opcode changes, so this block returns the ALU opcode to NOP_CODE between every pair of operations.

---
 rtl/alu_issue_ctrl.sv | 261 ++++++++++++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_ctrl
// Purpose  : Requester-side sequencer for the ALU core. It latches one ALU
//            request, drives the operands and the opcode, and waits a fixed
//            settle time. It then captures the results, updates the CY/AC/OV
//            PSW flags and hands the result to execute over valid/ready.
//            The ALU opcode returns to NOP_CODE between operations so that
//            each new request produces an opcode change at the ALU.
// Options  : define ALU_ISSUE_PARITY_EN to add the psw_p (8051 P flag) output.
// Revision : 1.0 - initial release
// ============================================================================

// Opcode map of the ALU core. It is normally provided by define_opcodes.v.
// The guards keep any map that was already included.
`ifndef ALU_ADD
  `define ALU_ADD  5'h00
`endif
`ifndef ALU_ADDC
  `define ALU_ADDC 5'h01
`endif
`ifndef ALU_SUBB
  `define ALU_SUBB 5'h02
`endif
`ifndef ALU_INC
  `define ALU_INC  5'h03
`endif
`ifndef ALU_DEC
  `define ALU_DEC  5'h04
`endif
`ifndef ALU_MUL
  `define ALU_MUL  5'h05
`endif
`ifndef ALU_DIV
  `define ALU_DIV  5'h06
`endif
`ifndef ALU_ANL
  `define ALU_ANL  5'h09
`endif
`ifndef ALU_ORL
  `define ALU_ORL  5'h0B
`endif
`ifndef ALU_RLC
  `define ALU_RLC  5'h0D
`endif
`ifndef ALU_RRC
  `define ALU_RRC  5'h0F
`endif

module alu_issue_ctrl #(
  parameter logic [4:0]  NOP_CODE    = 5'h1F,
  parameter int unsigned BASE_WAIT   = 1,
  parameter int unsigned MULDIV_WAIT = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [4:0] req_opcode,
  input  logic [7:0] req_op1,
  input  logic [7:0] req_op2,
  input  logic       req_bit,
  output logic [4:0] alu_opcode,
  output logic [7:0] alu_op1,
  output logic [7:0] alu_op2,
  output logic       alu_carry,
  output logic       alu_aux_carry,
  output logic       alu_bit,
  input  logic [7:0] alu_res1,
  input  logic [7:0] alu_res2,
  input  logic       alu_cy,
  input  logic       alu_ac,
  input  logic       alu_ov,
  output logic       result_valid,
  input  logic       result_ready,
  output logic [7:0] result_lo,
  output logic [7:0] result_hi,
  input  logic       psw_wr_en,
  input  logic [2:0] psw_wr_data,
  output logic       psw_cy,
  output logic       psw_ac,
`ifdef ALU_ISSUE_PARITY_EN
  output logic       psw_p,
`endif
  output logic       psw_ov
);

  localparam logic [7:0] BASE_W   = 8'(BASE_WAIT);
  localparam logic [7:0] MULDIV_W = 8'(MULDIV_WAIT);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETUP   = 3'd1,
    S_ISSUE   = 3'd2,
    S_WAIT    = 3'd3,
    S_CAPTURE = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t     state_q, state_d;
  logic [4:0] opc_q, opc_d;
  logic [7:0] op1_q, op1_d;
  logic [7:0] op2_q, op2_d;
  logic       bit_q, bit_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] lo_q, lo_d;
  logic [7:0] hi_q, hi_d;
  logic       cy_q, cy_d;
  logic       ac_q, ac_d;
  logic       ov_q, ov_d;
`ifdef ALU_ISSUE_PARITY_EN
  logic       p_q, p_d;
`endif

  logic [7:0] wait_len;
  assign wait_len = ((opc_q == `ALU_MUL) || (opc_q == `ALU_DIV)) ? MULDIV_W : BASE_W;

  // State sequencing, request latching, result capture and PSW flag update
  always_comb begin
    state_d = state_q;
    opc_d   = opc_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    bit_d   = bit_q;
    cnt_d   = cnt_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    cy_d    = cy_q;
    ac_d    = ac_q;
    ov_d    = ov_q;
`ifdef ALU_ISSUE_PARITY_EN
    p_d     = p_q;
`endif

    // External flag writes lose against the ALU update on the capture edge
    if (psw_wr_en && (state_q != S_CAPTURE)) begin
      {cy_d, ac_d, ov_d} = psw_wr_data;
    end

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          opc_d   = req_opcode;
          op1_d   = req_op1;
          op2_d   = req_op2;
          bit_d   = req_bit;
          state_d = S_SETUP;
        end
      end
      S_SETUP: state_d = S_ISSUE;
      S_ISSUE: begin
        if (wait_len == 8'd0) begin
          state_d = S_CAPTURE;
        end else begin
          cnt_d   = wait_len - 8'd1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 8'd0) begin
          state_d = S_CAPTURE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_CAPTURE: begin
        lo_d = alu_res1;
        hi_d = alu_res2;
        case (opc_q)
          `ALU_ADD, `ALU_ADDC, `ALU_SUBB: begin
            cy_d = alu_cy;
            ac_d = alu_ac;
            ov_d = alu_ov;
          end
          `ALU_MUL: begin
            cy_d = 1'b0;
            ov_d = alu_ov;
          end
          `ALU_DIV: begin
            cy_d = 1'b0;
            if (op2_q == 8'h00) begin
              // Divide by zero: the ALU bus is not trusted here
              lo_d = 8'hFF;
              hi_d = 8'hFF;
              ov_d = 1'b1;
            end else begin
              ov_d = alu_ov;
            end
          end
          `ALU_RRC, `ALU_RLC, `ALU_ORL, `ALU_ANL: cy_d = alu_cy;
          default: ;
        endcase
`ifdef ALU_ISSUE_PARITY_EN
        p_d = ^lo_d;
`endif
        state_d = S_DONE;
      end
      S_DONE: begin
        if (result_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with asynchronous reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      opc_q   <= NOP_CODE;
      op1_q   <= 8'h00;
      op2_q   <= 8'h00;
      bit_q   <= 1'b0;
      cnt_q   <= 8'h00;
      lo_q    <= 8'h00;
      hi_q    <= 8'h00;
      cy_q    <= 1'b0;
      ac_q    <= 1'b0;
      ov_q    <= 1'b0;
`ifdef ALU_ISSUE_PARITY_EN
      p_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      bit_q   <= bit_d;
      cnt_q   <= cnt_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      cy_q    <= cy_d;
      ac_q    <= ac_d;
      ov_q    <= ov_d;
`ifdef ALU_ISSUE_PARITY_EN
      p_q     <= p_d;
`endif
    end
  end

  // The opcode is live only from ISSUE through WAIT, so every request
  // presents a fresh opcode change to the ALU
  assign alu_opcode    = ((state_q == S_ISSUE) || (state_q == S_WAIT)) ? opc_q : NOP_CODE;
  assign alu_op1       = op1_q;
  assign alu_op2       = op2_q;
  assign alu_bit       = bit_q;
  assign alu_carry     = cy_q;
  assign alu_aux_carry = ac_q;
  assign req_ready     = (state_q == S_IDLE);
  assign result_valid  = (state_q == S_DONE);
  assign result_lo     = lo_q;
  assign result_hi     = hi_q;
  assign psw_cy        = cy_q;
  assign psw_ac        = ac_q;
  assign psw_ov        = ov_q;
`ifdef ALU_ISSUE_PARITY_EN
  assign psw_p         = p_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_issue_ctrl
// Purpose  : Self-checking bench for alu_issue_ctrl with a behavioural ALU
//            that evaluates on opcode change, and an expected-result queue.
// Revision : 1.0 - initial release
// ============================================================================

`ifndef ALU_ADD
  `define ALU_ADD  5'h00
`endif
`ifndef ALU_ADDC
  `define ALU_ADDC 5'h01
`endif
`ifndef ALU_SUBB
  `define ALU_SUBB 5'h02
`endif
`ifndef ALU_INC
  `define ALU_INC  5'h03
`endif
`ifndef ALU_MUL
  `define ALU_MUL  5'h05
`endif
`ifndef ALU_DIV
  `define ALU_DIV  5'h06
`endif
`ifndef ALU_ANL
  `define ALU_ANL  5'h09
`endif
`ifndef ALU_ORL
  `define ALU_ORL  5'h0B
`endif
`ifndef ALU_RLC
  `define ALU_RLC  5'h0D
`endif
`ifndef ALU_RRC
  `define ALU_RRC  5'h0F
`endif

module tb_alu_issue_ctrl;

  localparam logic [4:0] NOP_CODE    = 5'h1F;
  localparam int         BASE_WAIT   = 1;
  localparam int         MULDIV_WAIT = 3;

  typedef struct packed {
    logic [7:0] lo;
    logic [7:0] hi;
    logic       cy;
    logic       ac;
    logic       ov;
  } alu_out_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [4:0] req_opcode = 5'h00;
  logic [7:0] req_op1 = 8'h00;
  logic [7:0] req_op2 = 8'h00;
  logic       req_bit = 1'b0;
  logic [4:0] alu_opcode;
  logic [7:0] alu_op1, alu_op2;
  logic       alu_carry, alu_aux_carry, alu_bit;
  logic [7:0] alu_res1, alu_res2;
  logic       alu_cy, alu_ac, alu_ov;
  logic       result_valid;
  logic       result_ready = 1'b0;
  logic [7:0] result_lo, result_hi;
  logic       psw_wr_en = 1'b0;
  logic [2:0] psw_wr_data = 3'b000;
  logic       psw_cy, psw_ac, psw_ov;
`ifdef ALU_ISSUE_PARITY_EN
  logic       psw_p;
`endif

  int checks = 0;
  int errors = 0;
  alu_out_t sb[$];
  logic m_cy = 1'b0, m_ac = 1'b0, m_ov = 1'b0;
  int issues = 0;
  logic [4:0] last_opc = 5'h1F;
  alu_out_t alu_r = '0;

  alu_issue_ctrl #(
    .NOP_CODE   (NOP_CODE),
    .BASE_WAIT  (BASE_WAIT),
    .MULDIV_WAIT(MULDIV_WAIT)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_opcode   (req_opcode),
    .req_op1      (req_op1),
    .req_op2      (req_op2),
    .req_bit      (req_bit),
    .alu_opcode   (alu_opcode),
    .alu_op1      (alu_op1),
    .alu_op2      (alu_op2),
    .alu_carry    (alu_carry),
    .alu_aux_carry(alu_aux_carry),
    .alu_bit      (alu_bit),
    .alu_res1     (alu_res1),
    .alu_res2     (alu_res2),
    .alu_cy       (alu_cy),
    .alu_ac       (alu_ac),
    .alu_ov       (alu_ov),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result_lo    (result_lo),
    .result_hi    (result_hi),
    .psw_wr_en    (psw_wr_en),
    .psw_wr_data  (psw_wr_data),
    .psw_cy       (psw_cy),
    .psw_ac       (psw_ac),
`ifdef ALU_ISSUE_PARITY_EN
    .psw_p        (psw_p),
`endif
    .psw_ov       (psw_ov)
  );

  always #5 clock = ~clock;

  // Behavioural ALU; flag outputs it should not be trusted for are junk
  function automatic alu_out_t alu_eval(input logic [4:0] opc, input logic [7:0] a,
                                        input logic [7:0] b, input logic ci,
                                        input logic aci, input logic bi);
    alu_out_t r;
    logic [8:0] s;
    logic [4:0] h;
    logic [15:0] w;
    r = '0;
    case (opc)
      `ALU_ADD, `ALU_ADDC: begin
        s = {1'b0, a} + {1'b0, b} + ((opc == `ALU_ADDC) ? {8'd0, ci} : 9'd0);
        h = {1'b0, a[3:0]} + {1'b0, b[3:0]} + ((opc == `ALU_ADDC) ? {4'd0, ci} : 5'd0);
        r.lo = s[7:0]; r.hi = 8'h3C; r.cy = s[8]; r.ac = h[4];
        r.ov = (a[7] == b[7]) && (s[7] != a[7]);
      end
      `ALU_SUBB: begin
        s = {1'b0, a} - {1'b0, b} - {8'd0, ci};
        h = {1'b0, a[3:0]} - {1'b0, b[3:0]} - {4'd0, ci};
        r.lo = s[7:0]; r.hi = 8'hC3; r.cy = s[8]; r.ac = h[4];
        r.ov = (a[7] != b[7]) && (s[7] != a[7]);
      end
      `ALU_MUL: begin
        w = {8'd0, a} * {8'd0, b};
        r.lo = w[7:0]; r.hi = w[15:8]; r.ov = |w[15:8]; r.cy = 1'b1; r.ac = aci;
      end
      `ALU_DIV: begin
        if (b != 8'h00) begin r.lo = a / b; r.hi = a % b; end
        r.ov = 1'b0; r.cy = 1'b1; r.ac = aci;
      end
      `ALU_INC: begin
        w = {b, a} + 16'd1;
        r.lo = w[7:0]; r.hi = w[15:8]; r.cy = ~ci; r.ac = ~aci; r.ov = 1'b1;
      end
      `ALU_RRC: begin r.lo = {ci, a[7:1]}; r.hi = b; r.cy = a[0]; r.ac = ~aci; r.ov = 1'b1; end
      `ALU_RLC: begin r.lo = {a[6:0], ci}; r.hi = b; r.cy = a[7]; r.ac = ~aci; r.ov = 1'b1; end
      `ALU_ANL: begin r.lo = a & b; r.hi = b; r.cy = ci & bi; r.ac = ~aci; r.ov = 1'b1; end
      `ALU_ORL: begin r.lo = a | b; r.hi = b; r.cy = ci | bi; r.ac = ~aci; r.ov = 1'b1; end
      default: begin r.lo = a ^ b; r.hi = 8'hA5; r.cy = ~ci; r.ac = ~aci; r.ov = 1'b1; end
    endcase
    return r;
  endfunction

  // The ALU only re-evaluates when its opcode changes to a real operation
  always @(alu_opcode) begin
    if (alu_opcode != NOP_CODE)
      alu_r = alu_eval(alu_opcode, alu_op1, alu_op2, alu_carry, alu_aux_carry, alu_bit);
  end
  assign alu_res1 = alu_r.lo;
  assign alu_res2 = alu_r.hi;
  assign alu_cy   = alu_r.cy;
  assign alu_ac   = alu_r.ac;
  assign alu_ov   = alu_r.ov;

  // Count NOP -> operation transitions seen by the ALU
  always @(negedge clock) begin
    if (alu_opcode != NOP_CODE && last_opc == NOP_CODE) issues <= issues + 1;
    last_opc <= alu_opcode;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic psw_write(input logic [2:0] d);
    @(negedge clock);
    psw_wr_en = 1'b1; psw_wr_data = d;
    @(negedge clock);
    psw_wr_en = 1'b0;
    {m_cy, m_ac, m_ov} = d;
  endtask

  task automatic run_req(input string nm, input logic [4:0] opc, input logic [7:0] a,
                         input logic [7:0] b, input logic bi, input int hold,
                         input bit collide);
    alu_out_t r, e;
    int lat, wcyc;
    bit seen_issue, col_done;
    r = alu_eval(opc, a, b, m_cy, m_ac, bi);
    e = '0;
    e.lo = r.lo; e.hi = r.hi; e.cy = m_cy; e.ac = m_ac; e.ov = m_ov;
    case (opc)
      `ALU_ADD, `ALU_ADDC, `ALU_SUBB: begin e.cy = r.cy; e.ac = r.ac; e.ov = r.ov; end
      `ALU_MUL: begin e.cy = 1'b0; e.ov = r.ov; end
      `ALU_DIV: begin
        e.cy = 1'b0; e.ov = r.ov;
        if (b == 8'h00) begin e.lo = 8'hFF; e.hi = 8'hFF; e.ov = 1'b1; end
      end
      `ALU_RRC, `ALU_RLC, `ALU_ORL, `ALU_ANL: e.cy = r.cy;
      default: ;
    endcase
    {m_cy, m_ac, m_ov} = {e.cy, e.ac, e.ov};
    sb.push_back(e);
    wcyc = ((opc == `ALU_MUL) || (opc == `ALU_DIV)) ? MULDIV_WAIT : BASE_WAIT;

    @(negedge clock);
    check_eq({nm, ".req_ready_idle"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_opcode = opc; req_op1 = a; req_op2 = b; req_bit = bi;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    // First cycle after accept: operands live, opcode still idle
    check_eq({nm, ".setup_opc"}, 32'(alu_opcode), 32'(NOP_CODE));
    check_eq({nm, ".setup_op1"}, 32'(alu_op1), 32'(a));
    check_eq({nm, ".setup_op2"}, 32'(alu_op2), 32'(b));
    check_eq({nm, ".req_ready_busy"}, 32'(req_ready), 32'd0);
    lat = 1;
    seen_issue = 1'b0;
    col_done = 1'b0;
    while (!result_valid && lat < 40) begin
      @(negedge clock);
      psw_wr_en = 1'b0;
      lat++;
      if (alu_opcode != NOP_CODE) seen_issue = 1'b1;
      else if (collide && seen_issue && !col_done) begin
        // This cycle is the capture cycle: collide an all-ones flag write
        psw_wr_en = 1'b1; psw_wr_data = 3'b111; col_done = 1'b1;
      end
    end
    psw_wr_en = 1'b0;
    check_eq({nm, ".valid"}, 32'(result_valid), 32'd1);
    check_eq({nm, ".latency"}, 32'(lat), 32'(4 + wcyc));
    if (sb.size() > 0) e = sb.pop_front();
    check_eq({nm, ".lo"}, 32'(result_lo), 32'(e.lo));
    check_eq({nm, ".hi"}, 32'(result_hi), 32'(e.hi));
    check_eq({nm, ".flags"}, 32'({psw_cy, psw_ac, psw_ov}), 32'({e.cy, e.ac, e.ov}));
    check_eq({nm, ".carry_mirror"}, 32'({alu_carry, alu_aux_carry}), 32'({e.cy, e.ac}));
`ifdef ALU_ISSUE_PARITY_EN
    check_eq({nm, ".parity"}, 32'(psw_p), 32'(^e.lo));
`endif
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      check_eq({nm, ".hold_valid"}, 32'(result_valid), 32'd1);
      check_eq({nm, ".hold_ready"}, 32'(req_ready), 32'd0);
      check_eq({nm, ".hold_res"}, 32'({result_hi, result_lo}), 32'({e.hi, e.lo}));
      check_eq({nm, ".hold_flags"}, 32'({psw_cy, psw_ac, psw_ov}), 32'({e.cy, e.ac, e.ov}));
    end
    result_ready = 1'b1;
    @(negedge clock);
    result_ready = 1'b0;
    check_eq({nm, ".back_idle"}, 32'({result_valid, req_ready}), 32'b01);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin : main
    logic [4:0] ops [6];
    int i0;
    ops[0] = `ALU_ADDC; ops[1] = `ALU_SUBB; ops[2] = `ALU_ANL;
    ops[3] = `ALU_ORL;  ops[4] = `ALU_RLC;  ops[5] = 5'h1E;

    #2;
    check_eq("rst.opcode", 32'(alu_opcode), 32'(NOP_CODE));
    check_eq("rst.ready_valid", 32'({req_ready, result_valid}), 32'b10);
    check_eq("rst.data", 32'({alu_op1, alu_op2, result_lo, result_hi}), 32'd0);
    check_eq("rst.flags", 32'({psw_cy, psw_ac, psw_ov, alu_bit}), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    run_req("add", `ALU_ADD, 8'h7F, 8'h01, 1'b0, 0, 1'b0);
    psw_write(3'b100);
    run_req("mul", `ALU_MUL, 8'h10, 8'h10, 1'b0, 0, 1'b0);
    run_req("div0", `ALU_DIV, 8'h25, 8'h00, 1'b0, 0, 1'b0);
    run_req("div", `ALU_DIV, 8'h25, 8'h07, 1'b0, 0, 1'b0);

    i0 = issues;
    run_req("inc_a", `ALU_INC, 8'hFF, 8'h00, 1'b0, 0, 1'b0);
    run_req("inc_b", `ALU_INC, 8'hFF, 8'h00, 1'b0, 0, 1'b0);
    check_eq("inc.issues", 32'(issues - i0), 32'd2);

    psw_write(3'b100);
    run_req("rrc", `ALU_RRC, 8'h01, 8'h00, 1'b0, 3, 1'b0);
    run_req("add_collide", `ALU_ADD, 8'h01, 8'h01, 1'b0, 0, 1'b1);

    for (int k = 0; k < 6; k++) begin
      run_req($sformatf("mix%0d", k), ops[k], 8'($urandom_range(0, 255)),
              8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), k % 2, 1'b0);
    end

    // Reset in the middle of a multiply wait
    @(negedge clock);
    req_valid = 1'b1; req_opcode = `ALU_MUL; req_op1 = 8'h33; req_op2 = 8'h44;
    @(negedge clock);
    req_valid = 1'b0;
    for (int k = 0; k < 10 && alu_opcode == NOP_CODE; k++) @(negedge clock);
    check_eq("rstw.issued", 32'(alu_opcode), 32'(`ALU_MUL));
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check_eq("rstw.opcode", 32'(alu_opcode), 32'(NOP_CODE));
    check_eq("rstw.data", 32'({alu_op1, alu_op2, result_lo, result_hi}), 32'd0);
    check_eq("rstw.flags", 32'({psw_cy, psw_ac, psw_ov, result_valid}), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    {m_cy, m_ac, m_ov} = 3'b000;
    @(posedge clock);
    #1;
    check_eq("rstw.ready", 32'(req_ready), 32'd1);
    run_req("post_rst", `ALU_ADD, 8'h0F, 8'h01, 1'b0, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
